vga_scan_doubler: RTL and testbench

//  Line-doubling scan converter between the TIA pixel stream (160 px/line) and the VGA timing generator.
//  Two ping-pong line buffers: the TIA fills one while VGA scanout reads the other.

---
 rtl/vga_scan_doubler_pkg.sv | 21 ++
 rtl/vga_scan_doubler_if.sv | 37 +++
 rtl/vga_scan_doubler_line_buffer_ram.sv | 39 +++
 rtl/vga_scan_doubler.sv | 139 +++++++++++++
 tb/tb_vga_scan_doubler.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_scan_doubler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_doubler_pkg
//  Purpose  : Shared video constants for the TIA source, the VGA timing
//             generator and the scan doubler, plus the palette index type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package vga_scan_doubler_pkg;

    localparam int VGA_H_DISPLAY    = 640;  // visible VGA width
    localparam int VGA_V_DISPLAY    = 480;  // visible VGA height
    localparam int TIA_SRC_WIDTH    = 160;  // TIA pixels per line
    localparam int TIA_COLOR_BITS   = 7;    // NTSC TIA colour+luma index
    localparam int DEF_H_SCALE_LOG2 = 2;    // 4x horizontal replication
    localparam int VGA_BORDER_COLOR = 0;    // palette index outside display

    typedef logic [TIA_COLOR_BITS-1:0] color_t;

endpackage : vga_scan_doubler_pkg
`default_nettype wire

// File: rtl/vga_scan_doubler_if.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_doubler_if
//  Purpose  : TIA pixel stream into the scan doubler (valid/ready handshake
//             plus a line-start strobe).
//  Signals  : pix_valid  source pixel present
//             pix_ready  doubler accepts pixel (transfer on valid & ready)
//             pix_color  palette index of the pixel
//             pix_line   1-cycle strobe, source starts a new line
//  Modports : master = pixel source, slave = scan doubler
//  Revision : 1.0  initial release
// ============================================================================
interface vga_scan_doubler_if #(
    parameter int COLOR_BITS = 7
) ();

    logic                  pix_valid;
    logic                  pix_ready;
    logic [COLOR_BITS-1:0] pix_color;
    logic                  pix_line;

    modport master (
        output pix_valid,
        output pix_color,
        output pix_line,
        input  pix_ready
    );

    modport slave (
        input  pix_valid,
        input  pix_color,
        input  pix_line,
        output pix_ready
    );

endinterface : vga_scan_doubler_if
`default_nettype wire

// File: rtl/vga_scan_doubler_line_buffer_ram.sv
`default_nettype none
// ============================================================================
//  Module   : line_buffer_ram
//  Purpose  : Two ping-pong line buffers of SRC_WIDTH entries each, one write
//             port and one synchronous read port. Address = {sel, x}.
//  Ports    : clk      clock
//             we       write enable
//             wr_addr  {sel, x} write address
//             wr_data  write data
//             rd_addr  {sel, x} read address
//             rd_data  registered read data (1 cycle after rd_addr)
//  Revision : 1.0  initial release
// ============================================================================
module line_buffer_ram #(
    parameter int SRC_WIDTH  = 160,
    parameter int COLOR_BITS = 7,
    parameter int X_W        = $clog2(SRC_WIDTH)
) (
    input  wire logic                  clk,
    input  wire logic                  we,
    input  wire logic [X_W:0]          wr_addr,
    input  wire logic [COLOR_BITS-1:0] wr_data,
    input  wire logic [X_W:0]          rd_addr,
    output logic      [COLOR_BITS-1:0] rd_data
);

    // Contents are intentionally not reset. Reads with x >= SRC_WIDTH only
    // happen outside the visible area and their data is masked downstream.
    logic [COLOR_BITS-1:0] mem [2][SRC_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr[X_W]][wr_addr[X_W-1:0]] <= wr_data;
        end
        rd_data <= mem[rd_addr[X_W]][rd_addr[X_W-1:0]];
    end

endmodule : line_buffer_ram
`default_nettype wire

// File: rtl/vga_scan_doubler.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scan_doubler
//  Purpose  : Line-doubling scan converter from the 160 px/line TIA stream to
//             640x480 VGA. The TIA fills one line buffer while the VGA side
//             reads the other; pixels are replicated 2**H_SCALE_LOG2 times
//             horizontally and every line twice vertically.
//  Ports    : clk         pixel clock (shared with VGA timing generator)
//             rst_n       synchronous active-low reset
//             pix         pixel stream (slave modport)
//             hpos, vpos  VGA counters (unregistered)
//             display_on  VGA visible-area flag for hpos/vpos
//             color_out   palette index, 1 cycle after hpos/vpos
//             underrun    sticky: a swap point found the write line incomplete
//  Revision : 1.0  initial release
// ============================================================================
module vga_scan_doubler
    import vga_scan_doubler_pkg::*;
#(
    parameter int SRC_WIDTH    = TIA_SRC_WIDTH,
    parameter int COLOR_BITS   = TIA_COLOR_BITS,
    parameter int H_SCALE_LOG2 = DEF_H_SCALE_LOG2,
    parameter int H_DISPLAY    = VGA_H_DISPLAY,
    parameter int BORDER_COLOR = VGA_BORDER_COLOR
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    vga_scan_doubler_if.slave          pix,
    input  wire logic [9:0]            hpos,
    input  wire logic [9:0]            vpos,
    input  wire logic                  display_on,
    output logic      [COLOR_BITS-1:0] color_out,
    output logic                       underrun
);

    localparam int                    X_W    = $clog2(SRC_WIDTH);
    localparam logic [X_W-1:0]        X_LAST = X_W'(SRC_WIDTH - 1);
    localparam logic [COLOR_BITS-1:0] BORDER = COLOR_BITS'(BORDER_COLOR);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                  wr_sel;
    logic                  rd_sel;
    logic [X_W-1:0]        wr_x;
    logic                  line_ready;
    logic                  display_on_q;
    logic [COLOR_BITS-1:0] ram_q;

    // ------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------
    logic           xfer;
    logic           swap_point;
    logic [X_W-1:0] wr_addr_x;
    logic [9:0]     hpos_scaled;
    logic [X_W-1:0] rd_x;
    logic           unused_bits;

    assign pix.pix_ready = ~line_ready;
    assign xfer          = pix.pix_valid & ~line_ready;

    // End of the second copy of a source line; display_on is low here, so
    // switching the read buffer cannot tear a visible pixel.
    assign swap_point = (hpos == 10'(H_DISPLAY)) && vpos[0];

    // A line strobe that coincides with a transfer restarts the line at 0.
    assign wr_addr_x = pix.pix_line ? '0 : wr_x;

    assign hpos_scaled = hpos >> H_SCALE_LOG2;
    assign rd_x        = hpos_scaled[X_W-1:0];
    assign unused_bits = &{1'b0, vpos[9:1], hpos_scaled};

    // ------------------------------------------------------------------
    // Write side counter, line flag and buffer swap
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b1;
            wr_x       <= '0;
            line_ready <= 1'b0;
            underrun   <= 1'b0;
        end else if (swap_point && line_ready) begin
            // pix_ready is low whenever line_ready is set, so no transfer
            // can collide with the swap.
            rd_sel     <= wr_sel;
            wr_sel     <= ~wr_sel;
            wr_x       <= '0;
            line_ready <= 1'b0;
        end else begin
            if (swap_point) begin
                underrun <= 1'b1;
            end
            if (xfer) begin
                if (wr_addr_x == X_LAST) begin
                    // Hold at the last index; the swap clears it.
                    line_ready <= 1'b1;
                end else begin
                    wr_x <= wr_addr_x + 1'b1;
                end
            end else if (pix.pix_line) begin
                wr_x <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers
    // ------------------------------------------------------------------
    line_buffer_ram #(
        .SRC_WIDTH  (SRC_WIDTH),
        .COLOR_BITS (COLOR_BITS),
        .X_W        (X_W)
    ) u_ram (
        .clk     (clk),
        .we      (xfer),
        .wr_addr ({wr_sel, wr_addr_x}),
        .wr_data (pix.pix_color),
        .rd_addr ({rd_sel, rd_x}),
        .rd_data (ram_q)
    );

    // ------------------------------------------------------------------
    // Output: both mux inputs are flops clocked on the same edge as the
    // RAM read, giving exactly one cycle from hpos to color_out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            display_on_q <= 1'b0;
        end else begin
            display_on_q <= display_on;
        end
    end

    assign color_out = display_on_q ? ram_q : BORDER;

endmodule : vga_scan_doubler
`default_nettype wire

// File: tb/tb_vga_scan_doubler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scan_doubler
//  Purpose  : Self-checking bench for vga_scan_doubler. Stimulus pushes the
//             expected colour of each checked VGA cycle into a scoreboard; a
//             monitor pops and compares one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scan_doubler;
    import vga_scan_doubler_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] hpos = 10'd700;
    logic [9:0] vpos = 10'd0;
    logic       display_on = 1'b0;
    logic [6:0] color_out;
    logic       underrun;

    vga_scan_doubler_if #(.COLOR_BITS(TIA_COLOR_BITS)) pix_if ();

    vga_scan_doubler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix        (pix_if.slave),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .color_out  (color_out),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] color;
        int         tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic chk_now = 1'b0;
    logic chk_q = 1'b0;

    always @(posedge clk) chk_q <= chk_now;

    // Monitor: a checked cycle produces one output on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (chk_q) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_empty got=%h", color_out);
            end else begin
                e = sb.pop_front();
                if (color_out !== e.color) begin
                    n_bad++;
                    $display("FAIL color v=%0d h=%0d got=%h exp=%h",
                             e.tag / 1000, e.tag % 1000, color_out, e.color);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int h, input int v, input logic de,
                        input logic chk, input logic [6:0] exp_c);
        hpos       = 10'(h);
        vpos       = 10'(v);
        display_on = de;
        chk_now    = chk;
        if (chk) sb.push_back('{exp_c, v * 1000 + h});
        tick();
        chk_now = 1'b0;
    endtask

    task automatic idle();
        step(700, 0, 1'b0, 1'b0, 7'h00);
    endtask

    task automatic check(input string name, input logic [6:0] got,
                         input logic [6:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, want);
        end
    endtask

    // Present one pixel until accepted (bounded). pix_valid stays asserted.
    task automatic feed(input logic [6:0] c, input logic line);
        logic ok;
        ok = 1'b0;
        pix_if.pix_valid = 1'b1;
        pix_if.pix_color = c;
        pix_if.pix_line  = line;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = pix_if.pix_ready;
            idle();
            pix_if.pix_line = 1'b0;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL feed_timeout got=ready_low exp=accept");
        end
    endtask

    // Hand-chosen pixel patterns indexed by source x.
    function automatic logic [6:0] pat(input int kind, input int x);
        case (kind)
            0:       pat = 7'(x);
            1:       pat = 7'h55;
            2:       pat = 7'(x + 8'h40);
            3:       pat = 7'(x * 5 + 3);
            default: pat = 7'(x ^ 8'h2A);
        endcase
    endfunction

    task automatic feed_line(input int kind);
        for (int x = 0; x < 160; x++) feed(pat(kind, x), 1'b0);
        pix_if.pix_valid = 1'b0;
    endtask

    // One visible VGA line: every output pixel checked against the pattern.
    task automatic show_line(input int v, input int kind);
        for (int h = 0; h < 640; h++) step(h, v, 1'b1, 1'b1, pat(kind, h >> 2));
        idle();
    endtask

    initial begin
        pix_if.pix_valid = 1'b0;
        pix_if.pix_color = 7'h00;
        pix_if.pix_line  = 1'b0;

        // ---- 1: reset state, full ramp line, swap, doubled display ----
        idle();
        idle();
        rst_n = 1'b1;
        check("rst_pix_ready", 7'(pix_if.pix_ready), 7'd1);
        check("rst_underrun", 7'(underrun), 7'd0);
        check("rst_color_out", color_out, 7'h00);
        feed_line(0);
        check("full_pix_ready", 7'(pix_if.pix_ready), 7'd0);
        check("full_underrun", 7'(underrun), 7'd0);
        step(640, 1, 1'b0, 1'b0, 7'h00);
        check("swap_pix_ready", 7'(pix_if.pix_ready), 7'd1);
        show_line(2, 0);
        show_line(3, 0);

        // ---- 2: border outside display_on ----
        for (int h = 640; h < 648; h++) step(h, 2, 1'b0, 1'b1, 7'h00);
        step(100, 480, 1'b0, 1'b1, 7'h00);
        step(20, 500, 1'b0, 1'b1, 7'h00);
        step(4, 2, 1'b1, 1'b1, 7'h01);
        idle();

        // ---- 3: short line -> no swap, repeat, sticky underrun ----
        for (int x = 0; x < 100; x++) feed(7'h11, 1'b0);
        pix_if.pix_valid = 1'b0;
        step(640, 3, 1'b0, 1'b0, 7'h00);
        check("short_underrun", 7'(underrun), 7'd1);
        check("short_pix_ready", 7'(pix_if.pix_ready), 7'd1);
        show_line(4, 0);

        // ---- 4: resync strobes overwrite partial data ----
        pix_if.pix_line = 1'b1;
        idle();
        pix_if.pix_line = 1'b0;
        for (int x = 0; x < 50; x++) feed(7'h22, 1'b0);
        feed(7'h55, 1'b1);
        for (int x = 1; x < 160; x++) feed(7'h55, 1'b0);
        pix_if.pix_valid = 1'b0;
        check("resync_pix_ready", 7'(pix_if.pix_ready), 7'd0);
        pix_if.pix_line = 1'b1;
        idle();
        pix_if.pix_line = 1'b0;
        check("ignored_line_pix_ready", 7'(pix_if.pix_ready), 7'd0);
        step(640, 5, 1'b0, 1'b0, 7'h00);
        show_line(6, 1);
        check("sticky_underrun", 7'(underrun), 7'd1);

        // ---- 5: pix_valid held across the swap ----
        for (int x = 0; x < 160; x++) feed(pat(2, x), 1'b0);
        pix_if.pix_color = 7'h7F;
        idle();
        idle();
        idle();
        check("held_pix_ready", 7'(pix_if.pix_ready), 7'd0);
        step(640, 7, 1'b0, 1'b0, 7'h00);
        check("held_swap_ready", 7'(pix_if.pix_ready), 7'd1);
        feed_line(3);
        show_line(8, 2);
        step(640, 9, 1'b0, 1'b0, 7'h00);
        show_line(10, 3);
        show_line(11, 3);

        // ---- 6: reset mid-line ----
        for (int x = 0; x < 80; x++) feed(7'h33, 1'b0);
        pix_if.pix_valid = 1'b0;
        step(20, 12, 1'b1, 1'b0, 7'h00);
        rst_n = 1'b0;
        step(20, 12, 1'b1, 1'b0, 7'h00);
        rst_n = 1'b1;
        check("midrst_pix_ready", 7'(pix_if.pix_ready), 7'd1);
        check("midrst_color_out", color_out, 7'h00);
        check("midrst_underrun", 7'(underrun), 7'd0);
        feed_line(4);
        step(640, 11, 1'b0, 1'b0, 7'h00);
        show_line(12, 4);
        show_line(13, 4);
        check("final_underrun", 7'(underrun), 7'd0);

        idle();
        idle();
        check("sb_drained", 7'(sb.size()), 7'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_vga_scan_doubler
`default_nettype wire
